// File: rtl/pea_pkg.sv
// Shared definitions for the 1x1 PE array: geometry constants, feeder FSM
// states, the feeder pipeline tag and the array accumulator type.
package pea_pkg;

  localparam int COL    = 8;
  localparam int PE_LAT = 2;
  localparam int CH_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    RUN,
    DRAIN,
    DONE
  } feeder_state_e;

  // Travels alongside each issued (oc, ic) product until it reaches the psum buffer.
  typedef struct packed {
    logic valid;
    logic last_ic;
    logic last_oc;
  } tag_t;

  typedef logic signed [23:0] sum_t;

endpackage

// File: rtl/pea_1x1_feeder_if.sv
// Read bus between the feeder and the IFM / weight buffers.
// Both buffers return data one cycle after the request.
interface pea_1x1_feeder_if #(
  parameter int IFM_WIDTH  = 64,
  parameter int WGT_WIDTH  = 8,
  parameter int IFM_AWIDTH = 8,
  parameter int WGT_AWIDTH = 16
) ();

  logic                  ifm_req;
  logic [IFM_AWIDTH-1:0] ifm_addr;
  logic [IFM_WIDTH-1:0]  ifm_rdata;
  logic                  wgt_req;
  logic [WGT_AWIDTH-1:0] wgt_addr;
  logic [WGT_WIDTH-1:0]  wgt_rdata;

  modport master (
    output ifm_req, ifm_addr, wgt_req, wgt_addr,
    input  ifm_rdata, wgt_rdata
  );

  modport slave (
    input  ifm_req, ifm_addr, wgt_req, wgt_addr,
    output ifm_rdata, wgt_rdata
  );

endinterface

// File: rtl/pea_feeder_dly.sv
// Fixed-depth shift register that delays the feeder's per-issue tag so it
// lines up with the product leaving the PE pipeline.
module pea_feeder_dly #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pipe [DEPTH];

  // NOTE: unlike a data memory, every stage holds control tags, so all stages are
  // reset; otherwise a stale valid could emerge after a mid-tile reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/pea_1x1_feeder.sv
// Sequencer/feeder for the 1x1 PE array: walks oc/ic for one tile, reads the
// buffers and tags products. Define PEA_FEEDER_PERF_EN for busy/stall counters.
module pea_1x1_feeder #(
  parameter int COL        = pea_pkg::COL,
  parameter int IFM_WIDTH  = COL * 8,
  parameter int WGT_WIDTH  = 8,
  parameter int CH_W       = pea_pkg::CH_W,
  parameter int IFM_AWIDTH = 8,
  parameter int WGT_AWIDTH = 16,
  parameter int PE_LAT     = pea_pkg::PE_LAT
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [CH_W-1:0]        cfg_ic,
  input  logic [CH_W-1:0]        cfg_oc,
  input  logic [$clog2(COL):0]   cfg_cols,
  input  logic                   cfg_stride,
  input  logic                   ofm_ready,
  output logic                   busy,
  output logic                   done,
  pea_1x1_feeder_if.master       mem_bus,
  output logic                   stride,
  output logic                   ifm_read,
  output logic                   wgt_read,
  output logic [IFM_WIDTH-1:0]   ifm_group,
  output logic [WGT_WIDTH-1:0]   wgt_group,
  output logic [COL-1:0]         pvalid,
  output logic                   ic_done,
  output logic                   oc_done
`ifdef PEA_FEEDER_PERF_EN
  ,
  output logic [31:0]            perf_busy_cyc,
  output logic [31:0]            perf_stall_cyc
`endif
);

  import pea_pkg::*;

  localparam int DCW = $clog2(PE_LAT + 2);

  feeder_state_e         state_q, state_d;
  logic [CH_W-1:0]       cfg_ic_q, cfg_oc_q;
  logic [CH_W-1:0]       ic_q, oc_q;
  logic [COL-1:0]        cols_mask_d, cols_mask_q;
  logic                  stride_q;
  logic [WGT_AWIDTH-1:0] wgt_base_q;
  logic [DCW-1:0]        drain_q;
  logic                  rd_q;
  logic                  issue, last_ic, last_oc;
  tag_t                  tag_in, tag_out;

  assign issue   = (state_q == RUN);
  assign last_ic = (ic_q == cfg_ic_q);
  assign last_oc = (oc_q == cfg_oc_q);

  // A column count of zero means a full-width tile.
  always_comb begin
    cols_mask_d = '0;
    for (int i = 0; i < COL; i++)
      cols_mask_d[i] = (cfg_cols == '0) || (i < int'(cfg_cols));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d takes its current value before the case so every path assigns
  // it and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CHECK;
      CHECK:   if (ofm_ready) state_d = RUN;
      RUN:     if (last_ic) state_d = last_oc ? DRAIN : CHECK;
      DRAIN:   if (drain_q == DCW'(PE_LAT)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here let every register sample the pre-edge
  // values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cfg_ic_q    <= '0;
      cfg_oc_q    <= '0;
      cols_mask_q <= '0;
      stride_q    <= 1'b0;
      ic_q        <= '0;
      oc_q        <= '0;
      wgt_base_q  <= '0;
      drain_q     <= '0;
      rd_q        <= 1'b0;
    end else begin
      rd_q <= issue;
      case (state_q)
        IDLE: if (start) begin
          cfg_ic_q    <= cfg_ic;
          cfg_oc_q    <= cfg_oc;
          cols_mask_q <= cols_mask_d;
          stride_q    <= cfg_stride;
          ic_q        <= '0;
          oc_q        <= '0;
          wgt_base_q  <= '0;
          drain_q     <= '0;
        end
        RUN: begin
          if (last_ic) begin
            ic_q       <= '0;
            oc_q       <= oc_q + 1'b1;
            // Running base replaces oc*(cfg_ic+1).
            wgt_base_q <= wgt_base_q + WGT_AWIDTH'(cfg_ic_q) + WGT_AWIDTH'(1);
          end else begin
            ic_q <= ic_q + 1'b1;
          end
        end
        DRAIN: drain_q <= drain_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign tag_in.valid   = issue;
  assign tag_in.last_ic = issue && last_ic;
  assign tag_in.last_oc = issue && last_ic && last_oc;

  pea_feeder_dly #(
    .DEPTH (PE_LAT + 1),
    .WIDTH ($bits(tag_t))
  ) u_dly (
    .clk  (clk),
    .rstn (rstn),
    .d    (tag_in),
    .q    (tag_out)
  );

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  assign mem_bus.ifm_req  = issue;
  assign mem_bus.wgt_req  = issue;
  assign mem_bus.ifm_addr = issue ? IFM_AWIDTH'(ic_q) : '0;
  assign mem_bus.wgt_addr = issue ? wgt_base_q + WGT_AWIDTH'(ic_q) : '0;

  assign stride    = stride_q;
  assign ifm_read  = rd_q;
  assign wgt_read  = rd_q;
  assign ifm_group = rd_q ? mem_bus.ifm_rdata : '0;
  assign wgt_group = rd_q ? mem_bus.wgt_rdata : '0;

  assign pvalid  = tag_out.valid ? cols_mask_q : '0;
  assign ic_done = tag_out.last_ic;
  assign oc_done = tag_out.last_oc;

`ifdef PEA_FEEDER_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else if (state_q == IDLE && start) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (busy && perf_busy_cyc != '1)
        perf_busy_cyc <= perf_busy_cyc + 32'd1;
      if (state_q == CHECK && !ofm_ready && perf_stall_cyc != '1)
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pea_1x1_feeder.sv
// Directed bench for pea_1x1_feeder: per-cycle expected masks for each tile,
// a 1-cycle-latency buffer model, mid-tile reset and ignored restart.
module tb_pea_1x1_feeder;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [7:0]  cfg_ic, cfg_oc;
  logic [3:0]  cfg_cols;
  logic        cfg_stride;
  logic        ofm_ready;
  logic        busy, done, stride, ifm_read, wgt_read, ic_done, oc_done;
  logic [63:0] ifm_group;
  logic [7:0]  wgt_group;
  logic [7:0]  pvalid;
`ifdef PEA_FEEDER_PERF_EN
  logic [31:0] perf_busy_cyc, perf_stall_cyc;
`endif

  int n_vec = 0;
  int n_err = 0;

  pea_1x1_feeder_if bus ();

  pea_1x1_feeder dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .cfg_ic     (cfg_ic),
    .cfg_oc     (cfg_oc),
    .cfg_cols   (cfg_cols),
    .cfg_stride (cfg_stride),
    .ofm_ready  (ofm_ready),
    .busy       (busy),
    .done       (done),
    .mem_bus    (bus),
    .stride     (stride),
    .ifm_read   (ifm_read),
    .wgt_read   (wgt_read),
    .ifm_group  (ifm_group),
    .wgt_group  (wgt_group),
    .pvalid     (pvalid),
    .ic_done    (ic_done),
    .oc_done    (oc_done)
`ifdef PEA_FEEDER_PERF_EN
    ,
    .perf_busy_cyc  (perf_busy_cyc),
    .perf_stall_cyc (perf_stall_cyc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ifm_pat(input logic [7:0] a);
    return {a, 8'hC3, a, 8'h5A, a, 8'hE1, a, 8'h0F};
  endfunction

  function automatic logic [7:0] wgt_pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // Buffer model: data appears one cycle after the request.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.ifm_rdata <= '0;
      bus.wgt_rdata <= '0;
    end else begin
      if (bus.ifm_req) bus.ifm_rdata <= ifm_pat(bus.ifm_addr);
      if (bus.wgt_req) bus.wgt_rdata <= wgt_pat(bus.wgt_addr);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one tile for n cycles after start; bit c of each mask is the
  // expected value of that signal sampled 1ns after clock edge c.
  task automatic run_tile(input int id, input logic [7:0] ic, input logic [7:0] oc,
                          input logic [3:0] cols, input logic strd, input int n,
                          input logic [31:0] req_m, input logic [31:0] rd_m,
                          input logic [31:0] pv_m, input logic [31:0] icd_m,
                          input logic [31:0] ocd_m, input logic [31:0] done_m,
                          input logic [31:0] busy_m, input logic [7:0] pmask,
                          input int rdy_lo, input int rdy_hi, input int restart_at);
    int          k;
    logic [7:0]  la;
    logic [15:0] lw;
    k  = 0;
    la = '0;
    lw = '0;
    cfg_ic     = ic;
    cfg_oc     = oc;
    cfg_cols   = cols;
    cfg_stride = strd;
    start      = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        start      = 1'b0;
        cfg_ic     = 8'hFF;
        cfg_oc     = 8'hFF;
        cfg_cols   = 4'd3;
        cfg_stride = ~strd;
        check($sformatf("T%0d stride", id), 64'(stride), 64'(strd));
      end
      check($sformatf("T%0d c%0d busy", id, c), 64'(busy), 64'(busy_m[c]));
      check($sformatf("T%0d c%0d done", id, c), 64'(done), 64'(done_m[c]));
      check($sformatf("T%0d c%0d ifm_req", id, c), 64'(bus.ifm_req), 64'(req_m[c]));
      check($sformatf("T%0d c%0d wgt_req", id, c), 64'(bus.wgt_req), 64'(req_m[c]));
      check($sformatf("T%0d c%0d ifm_read", id, c), 64'(ifm_read), 64'(rd_m[c]));
      check($sformatf("T%0d c%0d wgt_read", id, c), 64'(wgt_read), 64'(rd_m[c]));
      check($sformatf("T%0d c%0d pvalid", id, c), 64'(pvalid), pv_m[c] ? 64'(pmask) : 64'd0);
      check($sformatf("T%0d c%0d ic_done", id, c), 64'(ic_done), 64'(icd_m[c]));
      check($sformatf("T%0d c%0d oc_done", id, c), 64'(oc_done), 64'(ocd_m[c]));
      if (rd_m[c]) begin
        check($sformatf("T%0d c%0d ifm_group", id, c), ifm_group, ifm_pat(la));
        check($sformatf("T%0d c%0d wgt_group", id, c), 64'(wgt_group), 64'(wgt_pat(lw)));
      end
      if (req_m[c]) begin
        la = 8'(k % (int'(ic) + 1));
        lw = 16'(k);
        check($sformatf("T%0d c%0d ifm_addr", id, c), 64'(bus.ifm_addr), 64'(la));
        check($sformatf("T%0d c%0d wgt_addr", id, c), 64'(bus.wgt_addr), 64'(lw));
        k++;
      end
      if (c == rdy_lo) ofm_ready = 1'b0;
      if (c == rdy_hi) ofm_ready = 1'b1;
      if (c == restart_at) begin
        start  = 1'b1;
        cfg_ic = 8'd0;
        cfg_oc = 8'd0;
      end else if (c == restart_at + 1) begin
        start = 1'b0;
      end
    end
  endtask

  initial begin
    rstn       = 1'b0;
    start      = 1'b0;
    cfg_ic     = '0;
    cfg_oc     = '0;
    cfg_cols   = '0;
    cfg_stride = 1'b0;
    ofm_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst ifm_req", 64'(bus.ifm_req), 64'd0);
    check("rst ifm_read", 64'(ifm_read), 64'd0);
    check("rst pvalid", 64'(pvalid), 64'd0);
    check("rst oc_done", 64'(oc_done), 64'd0);
    check("rst stride", 64'(stride), 64'd0);
    #3 rstn = 1'b1;
    @(posedge clk);
    #1;

    // ic=3, oc=1, full width: 8 issues with a CHECK bubble between ocs.
    run_tile(1, 8'd3, 8'd1, 4'd8, 1'b0, 15, 32'h07BC, 32'h0F78, 32'h3DE0,
             32'h2100, 32'h2000, 32'h4000, 32'h7FFE, 8'hFF, 0, 0, 0);
`ifdef PEA_FEEDER_PERF_EN
    check("T1 perf_busy", 64'(perf_busy_cyc), 64'd14);
    check("T1 perf_stall", 64'(perf_stall_cyc), 64'd0);
`endif

    // Single-issue tile: pvalid, ic_done and oc_done coincide.
    run_tile(2, 8'd0, 8'd0, 4'd8, 1'b0, 7, 32'h04, 32'h08, 32'h20,
             32'h20, 32'h20, 32'h40, 32'h7E, 8'hFF, 0, 0, 0);

    // Partial width, stride-2 mode; then cfg_cols=0 means full width.
    run_tile(3, 8'd1, 8'd0, 4'd5, 1'b1, 8, 32'h0C, 32'h18, 32'h60,
             32'h40, 32'h40, 32'h80, 32'hFE, 8'h1F, 0, 0, 0);
    run_tile(4, 8'd1, 8'd0, 4'd0, 1'b0, 8, 32'h0C, 32'h18, 32'h60,
             32'h40, 32'h40, 32'h80, 32'hFE, 8'hFF, 0, 0, 0);

    // ofm_ready low for 10 CHECK cycles at the oc=1 boundary.
    run_tile(5, 8'd1, 8'd1, 4'd8, 1'b0, 21, 32'h1800C, 32'h30018, 32'hC0060,
             32'h80040, 32'h80000, 32'h100000, 32'h1FFFFE, 8'hFF, 3, 14, 0);
`ifdef PEA_FEEDER_PERF_EN
    check("T5 perf_busy", 64'(perf_busy_cyc), 64'd20);
    check("T5 perf_stall", 64'(perf_stall_cyc), 64'd10);
`endif

    // Reset in the middle of RUN aborts the tile with no done pulse.
    cfg_ic     = 8'd3;
    cfg_oc     = 8'd1;
    cfg_cols   = 4'd8;
    cfg_stride = 1'b1;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("T6 pre-reset ifm_req", 64'(bus.ifm_req), 64'd1);
    rstn = 1'b0;
    #1;
    check("T6 rst busy", 64'(busy), 64'd0);
    check("T6 rst ifm_req", 64'(bus.ifm_req), 64'd0);
    check("T6 rst wgt_req", 64'(bus.wgt_req), 64'd0);
    check("T6 rst ifm_read", 64'(ifm_read), 64'd0);
    check("T6 rst pvalid", 64'(pvalid), 64'd0);
    check("T6 rst stride", 64'(stride), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("T6 hold%0d done", i), 64'(done), 64'd0);
      check($sformatf("T6 hold%0d pvalid", i), 64'(pvalid), 64'd0);
    end
    #2 rstn = 1'b1;

    // Full tile after the abort, with a start pulse mid-RUN that must be ignored.
    run_tile(7, 8'd3, 8'd1, 4'd8, 1'b0, 15, 32'h07BC, 32'h0F78, 32'h3DE0,
             32'h2100, 32'h2000, 32'h4000, 32'h7FFE, 8'hFF, 0, 0, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
